pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload width in bits (legal range 1..64).
REQ-002 SHALL have parameter RESET_VAL, default 0, meaning value loaded into both data registers on reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port count  output  2  entries held (0..2).

Function
REQ-013 SHALL define in-transfer as in_valid & in_ready, and out-transfer as out_valid & out_ready, both sampled at the rising edge of clk.
REQ-014 SHALL hold two registers, main and skid, and a state register with states EMPTY, ONE and TWO.
REQ-015 SHALL drive out_valid = (state != EMPTY), in_ready = (state != TWO), out_data = main, and count = 0/1/2 for EMPTY/ONE/TWO.
REQ-016 SHALL derive in_ready only from registered state, with no combinational path from out_ready or in_valid.
REQ-017 SHALL implement transition EMPTY with in-transfer -> ONE, main <= in_data.
REQ-018 SHALL implement transition ONE with in-transfer and no out-transfer -> TWO, skid <= in_data.
REQ-019 SHALL implement transition ONE with both transfers -> ONE, main <= in_data; this sustains one word per cycle.
REQ-020 SHALL implement transition ONE with out-transfer only -> EMPTY.
REQ-021 SHALL implement transition TWO with out-transfer -> ONE, main <= skid.
REQ-022 SHALL hold state and data when no transfer occurs.
REQ-023 SHALL have latency of exactly 1 cycle from in-transfer into EMPTY to out_valid high.
REQ-024 SHALL preserve word order; no word is duplicated or dropped except by flush or clr.
REQ-025 SHALL, on flush=1, force state to EMPTY at the next edge; any simultaneous in-transfer is discarded, a simultaneous out-transfer is considered consumed, and data registers hold their values.
REQ-026 SHALL keep out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-027 SHALL, on clr=1 at a rising edge, set state to EMPTY and main and skid to RESET_VAL; reset has priority over flush and all transfers.
REQ-028 SHALL set outputs during and after reset to out_valid=0, in_ready=1, count=0 and out_data=RESET_VAL.
REQ-029 SHALL, on reset mid-operation (state ONE or TWO), discard all entries in the same edge.

Structure
REQ-030 SHALL place the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) as localparams in the shared package cpu_pkg.
REQ-031 SHALL be a single flat module with no sub-module, and state encoding 2'd3 SHALL recover to EMPTY.

Verification
REQ-032 SHALL cover: clr=1 for 2 cycles with in_valid=1 and in_data=32'hAAAA_5555 -> out_valid=0, count=0, out_data=0, in_ready=1.
REQ-033 SHALL cover: write 32'h1 with out_ready=1 -> next cycle out_valid=1 and out_data=32'h1; streaming 1,2,3,4 back-to-back -> 1,2,3,4 out on consecutive cycles.
REQ-034 SHALL cover: out_ready=0 while writing 32'hA and 32'hB -> count=2, in_ready=0, out_data=32'hA; raising out_ready -> 32'hA then 32'hB, with count stepping 2,1,0.
REQ-035 SHALL cover: state TWO with flush=1 and in_valid=1 (32'hC) -> next cycle count=0, out_valid=0, and 32'hC is never output.
REQ-036 SHALL cover: clr=1 asserted in state TWO -> next cycle count=0, out_data=RESET_VAL; a subsequent write of 32'h7 emerges as the first word.
REQ-037 SHALL cover: random in_valid/out_ready over 10k cycles with WIDTH=8 -> output sequence equals input sequence, out_data stable while stalled, and count never exceeds 2.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the pipeline skid register.
//                Holds the occupancy-state encoding and its enum type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Occupancy-state encoding of the skid register (number of held words).
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_ONE   = ONE,
    ST_TWO   = TWO
  } skid_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Two-entry valid/ready pipeline register with a skid slot.
//                in_ready is a pure function of registered state, so the
//                ready path is cut between upstream and downstream while
//                still sustaining one word per cycle.
//  Ports       : clk       - rising-edge clock
//                clr       - synchronous active-high reset
//                flush     - synchronous discard of all held entries
//                in_valid  / in_data  / in_ready  - upstream handshake
//                out_valid / out_data / out_ready - downstream handshake
//                count     - number of held entries (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic w_in_xfer;
  logic w_out_xfer;

  // Outputs come straight from registers: no combinational path from
  // out_ready or in_valid reaches in_ready.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_TWO);
  assign out_data  = main_q;

  always_comb begin
    count = 2'd0;
    case (state_q)
      ST_ONE:  count = 2'd1;
      ST_TWO:  count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  assign w_in_xfer  = in_valid  & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          // Pass-through: the consumed word is replaced in place.
          main_d = in_data;
        end else if (w_in_xfer) begin
          state_d = ST_TWO;
          skid_d  = in_data;
        end else if (w_out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (w_out_xfer) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        // Unused encoding 2'd3 falls back to an empty register.
        state_d = ST_EMPTY;
      end
    endcase

    // Flush drops every held word; data registers keep their contents.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule : pipe_skid_reg
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_reg
//  Description : Self-checking bench for pipe_skid_reg. Directed scenarios on
//                a 32-bit instance, randomized traffic on an 8-bit instance
//                compared against a queue-based occupancy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        clr, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  count;

  // 8-bit instance
  logic        clr8, flush8, iv8, ir8, ov8, or8;
  logic [7:0]  id8, od8;
  logic [1:0]  cnt8;

  int checks   = 0;
  int failures = 0;

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk      (clk),
    .clr      (clr),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'h0)) dut8 (
    .clk      (clk),
    .clr      (clr8),
    .flush    (flush8),
    .in_valid (iv8),
    .in_data  (id8),
    .in_ready (ir8),
    .out_valid(ov8),
    .out_data (od8),
    .out_ready(or8),
    .count    (cnt8)
  );

  // Advance one clock; inputs are sampled at the edge, outputs read 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    drive(1'b1, 32'hAAAA_5555, 1'b0);
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, out_valid); end
      checks++;
      if (count !== 2'd0) begin failures++; $display("FAIL reset_count cyc%0d: got %0d want 0", c, count); end
      checks++;
      if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data cyc%0d: got %h want 0", c, out_data); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready cyc%0d: got %b want 1", c, in_ready); end
    end
    clr = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_single_write();
    drive(1'b1, 32'h1, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1) begin
      failures++; $display("FAIL single_write: got valid=%b data=%h want valid=1 data=1", out_valid, out_data);
    end
    checks++;
    if (count !== 2'd1) begin failures++; $display("FAIL single_count: got %0d want 1", count); end
    step();
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      failures++; $display("FAIL single_drain: got valid=%b count=%0d want valid=0 count=0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 1'b1);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || count !== 2'd1) begin
        failures++;
        $display("FAIL b2b_word%0d: got valid=%b data=%h count=%0d want valid=1 data=%h count=1",
                 i, out_valid, out_data, count, 32'(i));
      end
    end
    drive(1'b0, 32'h0, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'hA, 1'b0);
    step();
    drive(1'b1, 32'hB, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
      failures++;
      $display("FAIL stall_full: got count=%0d in_ready=%b data=%h want count=2 in_ready=0 data=a",
               count, in_ready, out_data);
    end
    step();
    checks++;
    if (count !== 2'd2 || out_data !== 32'hA) begin
      failures++; $display("FAIL stall_hold: got count=%0d data=%h want count=2 data=a", count, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (count !== 2'd1 || out_valid !== 1'b1 || out_data !== 32'hB) begin
      failures++; $display("FAIL stall_drain1: got count=%0d valid=%b data=%h want count=1 valid=1 data=b",
                           count, out_valid, out_data);
    end
    step();
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL stall_drain2: got count=%0d valid=%b want count=0 valid=0", count, out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h11, 1'b0);
    step();
    drive(1'b1, 32'h22, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 32'hC, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_two: got count=%0d valid=%b in_ready=%b want 0 0 1", count, out_valid, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL flush_no_c cyc%0d: got valid=%b data=%h want valid=0", c, out_valid, out_data);
      end
    end
    // Flush from ONE with a simultaneous in-transfer: the new word is dropped.
    drive(1'b1, 32'h55, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h66, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_one: got count=%0d valid=%b want count=0 valid=0", count, out_valid);
    end
  endtask

  task automatic test_clr_mid();
    drive(1'b1, 32'h33, 1'b0);
    step();
    drive(1'b1, 32'h44, 1'b0);
    step();
    clr   = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h99, 1'b1);
    step();
    clr   = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++; $display("FAIL clr_mid: got count=%0d valid=%b data=%h want 0 0 0", count, out_valid, out_data);
    end
    drive(1'b1, 32'h7, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h7) begin
      failures++; $display("FAIL clr_first_word: got valid=%b data=%h want valid=1 data=7", out_valid, out_data);
    end
    step();
  endtask

  // Reference: the register is a FIFO of at most two words.
  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] prev_data;
    bit         prev_stall;
    bit         in_x, out_x;
    clr8 = 1'b1; flush8 = 1'b0; iv8 = 1'b0; id8 = 8'h0; or8 = 1'b0;
    step();
    clr8 = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'h0;
    for (int i = 0; i < 10000; i++) begin
      checks++;
      if (ov8 !== (q.size() > 0)) begin
        failures++; $display("FAIL rnd_valid cyc%0d: got %b want %0d", i, ov8, q.size() > 0);
      end
      checks++;
      if (ir8 !== (q.size() < 2)) begin
        failures++; $display("FAIL rnd_in_ready cyc%0d: got %b want %0d", i, ir8, q.size() < 2);
      end
      checks++;
      if (int'(cnt8) != q.size() || cnt8 > 2'd2) begin
        failures++; $display("FAIL rnd_count cyc%0d: got %0d want %0d", i, cnt8, q.size());
      end
      if (q.size() > 0) begin
        checks++;
        if (od8 !== q[0]) begin
          failures++; $display("FAIL rnd_data cyc%0d: got %h want %h", i, od8, q[0]);
        end
      end
      if (prev_stall) begin
        checks++;
        if (od8 !== prev_data) begin
          failures++; $display("FAIL rnd_stable cyc%0d: got %h want %h", i, od8, prev_data);
        end
      end

      iv8    = 1'($urandom_range(0, 1));
      id8    = 8'($urandom);
      or8    = 1'($urandom_range(0, 1));
      flush8 = ($urandom_range(0, 63) == 0);

      in_x       = iv8 && (q.size() < 2);
      out_x      = (q.size() > 0) && or8;
      prev_stall = (q.size() > 0) && !or8 && !flush8;
      prev_data  = od8;
      if (flush8) begin
        q.delete();
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x)  q.push_back(id8);
      end
      step();
    end
    iv8 = 1'b0; or8 = 1'b0; flush8 = 1'b0;
  endtask

  initial begin
    clr = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    clr8 = 1'b1; flush8 = 1'b0; iv8 = 1'b0; id8 = 8'h0; or8 = 1'b0;
    #2;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_stall();
    test_flush();
    test_clr_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_skid_reg
`default_nettype wire
